sobel_frame_scheduler: RTL and testbench

Streams a raster-order 8-bit grayscale frame in. Keeps two line buffers and a 3x3 window register, and sequences the combinational ReRAM_Accelerator, one trigger per interior pixel. Returns clamped edge strengths on a valid/ready output stream. It sits between the pixel DMA/loader and the result writeback.

---
 rtl/sobel_pkg.sv | 17 +
 rtl/ReRAM_Accelerator.sv | 25 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_frame_scheduler.sv | 130 +++++++++++++
 tb/tb_sobel_frame_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_pkg.sv
// Shared widths, FSM encoding and 3x3 window packing for the Sobel frame scheduler.
package sobel_pkg;
   localparam int WIN_W = 72;
   localparam int PIX_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Tap 0 is top-left and sits in the MSBs; taps run row-major.
   function automatic int tap_lsb(input int idx);
      return (8 - idx) * PIX_W;
   endfunction
endpackage

// File: rtl/ReRAM_Accelerator.sv
// Combinational stand-in for the accelerator: |Gx|+|Gy| Sobel magnitude clamped to 255.
module ReRAM_Accelerator
   import sobel_pkg::*;
(
   input  logic             trigger,
   input  logic [WIN_W-1:0] pixel_window,
   output logic [31:0]      result
);
   logic signed [12:0] p [9];
   logic signed [12:0] gx, gy, ax, ay, mag;

   function automatic logic [PIX_W-1:0] sat8(input logic signed [12:0] v);
      return (v > 13'sd255) ? 8'hFF : v[PIX_W-1:0];
   endfunction

   always_comb begin
      for (int i = 0; i < 9; i++) p[i] = {5'b0, pixel_window[tap_lsb(i) +: PIX_W]};
      gx  = (p[2] + (p[5] <<< 1) + p[8]) - (p[0] + (p[3] <<< 1) + p[6]);
      gy  = (p[6] + (p[7] <<< 1) + p[8]) - (p[0] + (p[1] <<< 1) + p[2]);
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      mag = ax + ay;
      result = trigger ? {24'd0, sat8(mag)} : 32'd0;
   end
endmodule

// File: rtl/sobel_line_buffer.sv
// Two-row shift line buffer: one shared column address, asynchronous read, distributed RAM.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int COL_W = $clog2(IMG_W)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [COL_W-1:0] col,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] tap_r1,
   output logic [PIX_W-1:0] tap_r2
);
   logic [PIX_W-1:0] row0 [IMG_W];
   logic [PIX_W-1:0] row1 [IMG_W];

   always_ff @(posedge clk) begin
      if (we) begin
         row1[col] <= row0[col];
         row0[col] <= din;
      end
   end

   assign tap_r1 = row0[col];
   assign tap_r2 = row1[col];
endmodule

// File: rtl/sobel_frame_scheduler.sv
// Raster-order frame scheduler: line buffers + 3x3 window feeding the Sobel accelerator,
// results returned on a valid/ready stream with backpressure.
module sobel_frame_scheduler
   import sobel_pkg::*;
#(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int COL_W = $clog2(IMG_W),
   parameter int ROW_W = $clog2(IMG_H)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             frame_done,
   input  logic             in_valid,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             in_ready,
   output logic             acc_trigger,
   output logic [WIN_W-1:0] acc_window,
   input  logic [31:0]      acc_result,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_pixel,
   input  logic             out_ready
);
   state_t           state, state_nx;
   logic [COL_W-1:0] col;
   logic [ROW_W-1:0] row;
   logic             vld_p1;
   logic [WIN_W-1:0] window_p1, window_nx;
   logic [PIX_W-1:0] tap_r1, tap_r2;
   logic             stall, accept, last_col, last_pix, win_ok;
   logic             unused_result_hi;

   assign unused_result_hi = ^acc_result[31:PIX_W];
   assign stall    = out_valid & ~out_ready;
   assign accept   = in_valid & in_ready;
   assign last_col = (col == COL_W'(IMG_W - 1));
   assign last_pix = last_col & (row == ROW_W'(IMG_H - 1));
   assign win_ok   = (row >= ROW_W'(2)) & (col >= COL_W'(2));

   sobel_line_buffer #(.IMG_W(IMG_W), .COL_W(COL_W)) u_lb (
      .clk    (clk),
      .we     (accept),
      .col    (col),
      .din    (in_pixel),
      .tap_r1 (tap_r1),
      .tap_r2 (tap_r2)
   );

   always_comb begin
      window_nx = window_p1;
      for (int r = 0; r < 3; r++) begin
         window_nx[tap_lsb(3*r)   +: PIX_W] = window_p1[tap_lsb(3*r+1) +: PIX_W];
         window_nx[tap_lsb(3*r+1) +: PIX_W] = window_p1[tap_lsb(3*r+2) +: PIX_W];
      end
      window_nx[tap_lsb(2) +: PIX_W] = tap_r2;
      window_nx[tap_lsb(5) +: PIX_W] = tap_r1;
      window_nx[tap_lsb(8) +: PIX_W] = in_pixel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (abort && state != IDLE) state_nx = IDLE;
      else begin
         case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && last_pix) state_nx = DRAIN;
            DRAIN:   if (!vld_p1 && !out_valid) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      busy       = (state != IDLE);
      frame_done = (state == DONE);
      in_ready   = (state == RUN) & ~stall;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         row       <= '0;
         vld_p1    <= 1'b0;
         window_p1 <= '0;
         out_valid <= 1'b0;
         out_pixel <= '0;
      end else if (abort && state != IDLE) begin
         vld_p1    <= 1'b0;
         out_valid <= 1'b0;
      end else if (state == IDLE) begin
         if (start) begin
            col       <= '0;
            row       <= '0;
            vld_p1    <= 1'b0;
            out_valid <= 1'b0;
         end
      end else begin
         // stage 2: capture accelerator result, release on handshake
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (vld_p1 && !stall) begin
            out_pixel <= acc_result[PIX_W-1:0];
            out_valid <= 1'b1;
            vld_p1    <= 1'b0;
         end
         // stage 1: shift window; border positions load but are not marked valid
         if (accept) begin
            window_p1 <= window_nx;
            vld_p1    <= win_ok;
            if (last_col) begin
               col <= '0;
               row <= (row == ROW_W'(IMG_H - 1)) ? '0 : row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

   assign acc_trigger = vld_p1;
   assign acc_window  = window_p1;
endmodule

// File: tb/tb_sobel_frame_scheduler.sv
// Directed bench for the Sobel frame scheduler: 4x4 and 8x8 instances with a result scoreboard.
module tb_sobel_frame_scheduler;
   import sobel_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, start, abort, in_valid, out_ready, sel;
   logic [7:0]  in_pixel;

   logic        busy4, fd4, ir4, trig4, ov4, busy8, fd8, ir8, trig8, ov8;
   logic [71:0] win4, win8;
   logic [31:0] res4, res8;
   logic [7:0]  op4, op8;
   logic        start4, start8;

   assign start4 = start & ~sel;
   assign start8 = start & sel;

   sobel_frame_scheduler #(.IMG_W(4), .IMG_H(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort), .busy(busy4), .frame_done(fd4),
      .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(ir4), .acc_trigger(trig4),
      .acc_window(win4), .acc_result(res4), .out_valid(ov4), .out_pixel(op4), .out_ready(out_ready));
   ReRAM_Accelerator u_acc4 (.trigger(trig4), .pixel_window(win4), .result(res4));

   sobel_frame_scheduler #(.IMG_W(8), .IMG_H(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .abort(abort), .busy(busy8), .frame_done(fd8),
      .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(ir8), .acc_trigger(trig8),
      .acc_window(win8), .acc_result(res8), .out_valid(ov8), .out_pixel(op8), .out_ready(out_ready));
   ReRAM_Accelerator u_acc8 (.trigger(trig8), .pixel_window(win8), .result(res8));

   logic        busy, frame_done, in_ready, acc_trigger, out_valid;
   logic [71:0] acc_window;
   logic [7:0]  out_pixel;
   assign busy        = sel ? busy8 : busy4;
   assign frame_done  = sel ? fd8   : fd4;
   assign in_ready    = sel ? ir8   : ir4;
   assign acc_trigger = sel ? trig8 : trig4;
   assign out_valid   = sel ? ov8   : ov4;
   assign acc_window  = sel ? win8  : win4;
   assign out_pixel   = sel ? op8   : op4;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         n_hs = 0;
   int         last_hs_cyc = 0;
   logic [7:0] pix [64];
   logic [7:0] q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pv(input int r, input int c, input int w);
      return int'(pix[r*w + c]);
   endfunction

   function automatic logic [7:0] ref_px(input int r, input int c, input int w);
      int gx, gy, m;
      gx = (pv(r-2,c,w) + 2*pv(r-1,c,w) + pv(r,c,w)) - (pv(r-2,c-2,w) + 2*pv(r-1,c-2,w) + pv(r,c-2,w));
      gy = (pv(r,c-2,w) + 2*pv(r,c-1,w) + pv(r,c,w)) - (pv(r-2,c-2,w) + 2*pv(r-2,c-1,w) + pv(r-2,c,w));
      m  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
      return (m > 255) ? 8'd255 : 8'(m);
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("scoreboard_nonempty", 72'(q.size() != 0), 72'd1);
         if (q.size() != 0) chk("out_pixel", 72'(out_pixel), 72'(q.pop_front()));
         n_hs        <= n_hs + 1;
         last_hs_cyc <= cyc;
      end
   end

   // vmode/rmode: 0 = always asserted, 1 = random; rmode 2 = 5-cycle stall on first result.
   task automatic run_frame(input int w, input int h, input int vmode, input int rmode,
                            input int stop_after, input bit b2b);
      int          idx, n, guard, s, base, nres, r, c;
      bit          done, pend22, trig_seen, first;
      logic [7:0]  hold_pix;
      logic [71:0] hold_win, exp_win;
      idx = 0; n = w*h; guard = 0; s = 0; base = n_hs; nres = (w-2)*(h-2);
      done = 0; pend22 = 0; trig_seen = 0; first = 1;
      hold_pix = '0; hold_win = '0; exp_win = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) exp_win = {exp_win[63:0], pix[i*w + j]};
      if (!start) begin
         @(posedge clk); #1 start = 1'b1;
      end
      @(posedge clk); #1 start = 1'b0;
      while (!done && guard < 3000) begin
         in_valid = (idx < n) && (vmode == 0 || $urandom_range(3) != 0);
         in_pixel = (idx < n) ? pix[idx] : 8'h00;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(2) != 0);
            default: out_ready = (s >= 5);
         endcase
         @(negedge clk);
         if (first) chk("busy_after_start", 72'(busy), 72'd1);
         first = 0;
         if (pend22) begin
            chk("trigger_after_px22", 72'({trig_seen, acc_trigger}), 72'b01);
            pend22 = 0;
         end
         if (acc_trigger && !trig_seen) begin
            trig_seen = 1;
            chk("first_window", acc_window, exp_win);
         end
         if (rmode == 2 && out_valid && s < 5) begin
            if (s == 0) begin
               hold_pix = out_pixel;
               hold_win = acc_window;
            end else begin
               chk("stall_out_pixel", 72'(out_pixel), 72'(hold_pix));
               chk("stall_acc_window", acc_window, hold_win);
            end
            chk("stall_in_ready", 72'(in_ready), 72'd0);
            s++;
         end
         if (in_valid && in_ready) begin
            r = idx / w;
            c = idx % w;
            if (r >= 2 && c >= 2) q.push_back(ref_px(r, c, w));
            if (idx == 2*w + 2) pend22 = 1;
            idx++;
         end
         if (frame_done) begin
            done = 1;
            chk("done_after_last_hs", 72'(cyc), 72'(last_hs_cyc + 2));
            chk("result_count", 72'(n_hs - base), 72'(nres));
            chk("scoreboard_drained", 72'(q.size()), 72'd0);
         end
         if (stop_after >= 0 && idx >= stop_after) break;
         @(posedge clk); #1;
         guard++;
      end
      if (stop_after < 0) begin
         chk("frame_done_seen", 72'(done), 72'd1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         start    = b2b;
         @(negedge clk);
         chk("busy_after_done", 72'(busy), 72'd0);
         chk("done_single_pulse", 72'(frame_done), 72'd0);
      end
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_busy"},        72'(busy),        72'd0);
      chk({tag, "_frame_done"},  72'(frame_done),  72'd0);
      chk({tag, "_in_ready"},    72'(in_ready),    72'd0);
      chk({tag, "_acc_trigger"}, 72'(acc_trigger), 72'd0);
      chk({tag, "_acc_window"},  acc_window,       72'd0);
      chk({tag, "_out_valid"},   72'(out_valid),   72'd0);
      chk({tag, "_out_pixel"},   72'(out_pixel),   72'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
      in_pixel = '0; out_ready = 1'b1; sel = 1'b0;
      #3;
      check_all_zero("reset4");
      sel = 1'b1;
      #1 check_all_zero("reset8");
      sel = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Flat 4x4 frame, then back-to-back start into the vertical-edge frame.
      for (int i = 0; i < 16; i++) pix[i] = 8'd128;
      run_frame(4, 4, 0, 0, -1, 1'b1);
      for (int i = 0; i < 16; i++) pix[i] = ((i % 4) >= 2) ? 8'd255 : 8'd0;
      run_frame(4, 4, 0, 0, -1, 1'b0);

      // Same edge frame with downstream stalled on the first result.
      run_frame(4, 4, 0, 2, -1, 1'b0);

      // Abort mid-frame, then a fresh flat frame.
      for (int i = 0; i < 16; i++) pix[i] = 8'd128;
      run_frame(4, 4, 0, 0, 11, 1'b0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      abort    = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_busy", 72'(busy), 72'd0);
      chk("abort_out_valid", 72'(out_valid), 72'd0);
      for (int k = 0; k < 3; k++) begin
         chk("abort_no_done", 72'(frame_done), 72'd0);
         @(negedge clk);
      end
      q.delete();
      run_frame(4, 4, 0, 0, -1, 1'b0);

      // 8x8 random pixels with random valid/ready.
      sel = 1'b1;
      for (int i = 0; i < 64; i++) pix[i] = 8'($urandom);
      run_frame(8, 8, 1, 1, -1, 1'b0);

      // Asynchronous reset mid-frame, then a fresh random frame.
      for (int i = 0; i < 64; i++) pix[i] = 8'($urandom);
      run_frame(8, 8, 1, 1, 20, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("mid_reset");
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      q.delete();
      for (int i = 0; i < 64; i++) pix[i] = 8'($urandom);
      run_frame(8, 8, 1, 1, -1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
